// File: rtl/ec_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ec_op_sequencer_if
// Purpose  : Request/acknowledge bus between the EC point-operation sequencer
//            and a shared modular multiplier.
// Signals  : mm_req  - multiply request (master -> slave)
//            mm_a    - multiplicand, held while mm_req=1
//            mm_b    - multiplier, held while mm_req=1
//            mm_p    - modulus, held while mm_req=1
//            mm_ack  - result valid, only meaningful while mm_req=1
//            mm_res  - (mm_a*mm_b) mod mm_p, valid with mm_ack
// Revision : 1.0 - initial release
// ============================================================================
interface ec_op_sequencer_if #(
  parameter int W = 6
) ();
  logic         mm_req;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_p;
  logic         mm_ack;
  logic [W-1:0] mm_res;

  modport master (output mm_req, mm_a, mm_b, mm_p, input  mm_ack, mm_res);
  modport slave  (input  mm_req, mm_a, mm_b, mm_p, output mm_ack, mm_res);
endinterface
`default_nettype wire

// File: rtl/ec_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ec_op_sequencer
// Purpose  : Computes R = P + Q on a short Weierstrass curve over GF(p).
//            Selects add / double / point-at-infinity, performs modular
//            add/sub locally and sends every modular multiply to a shared
//            external multiplier. The slope denominator is inverted by
//            Fermat exponentiation den^(p-2), square-and-multiply MSB first.
// Ports    : clk, rst_n (async, active low)
//            in_valid, in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a - operands
//            busy      - operation in progress (through the out_valid cycle)
//            out_valid - one-cycle result strobe
//            out_Rx, out_Ry, out_inf - result, zero outside out_valid
//            mm        - multiplier bus (master side)
// Revision : 1.0 - initial release
// ============================================================================
module ec_op_sequencer #(
  parameter int W = 6
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         in_valid,
  input  wire logic [W-1:0] in_Px,
  input  wire logic [W-1:0] in_Py,
  input  wire logic [W-1:0] in_Qx,
  input  wire logic [W-1:0] in_Qy,
  input  wire logic [W-1:0] in_prime,
  input  wire logic [W-1:0] in_a,
  output logic              busy,
  output logic              out_valid,
  output logic [W-1:0]      out_Rx,
  output logic [W-1:0]      out_Ry,
  output logic              out_inf,
  ec_op_sequencer_if.master mm
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLS, S_NUM, S_INV, S_LAM, S_LSQ, S_RX, S_RYM, S_OUT
  } state_t;

  state_t r_state, w_nstate;

  logic [W-1:0]  r_px, r_py, r_qx, r_qy, r_p, r_a;
  logic [W-1:0]  r_num, r_den, r_acc, r_lam, r_t, r_rx, r_ry;
  logic          r_inf;
  logic [IW-1:0] r_bit;
  logic          r_phase;   // INV: 0 = squaring step, 1 = multiply-by-den step
  logic          r_mm_req;
  logic [W-1:0]  r_mm_a, r_mm_b, r_mm_p;

  logic          w_issue, w_done, w_same_x, w_is_inf, w_ebit;
  logic [W-1:0]  w_opa, w_opb, w_e;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, y, m);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, y, m);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[W]) d = d + {1'b0, m};  // borrow: wrap back into [0, m)
    return d[W-1:0];
  endfunction

  assign w_done   = r_mm_req && mm.mm_ack;
  assign w_same_x = (r_px == r_qx);
  assign w_is_inf = w_same_x && ((r_py != r_qy) || (r_py == '0));
  assign w_e      = r_p - W'(2);
  assign w_ebit   = w_e[r_bit];

  // Next state plus the multiply operands of the current state. A multiply
  // is issued whenever a multiply state has no request outstanding; because
  // the request register clears in the ack cycle, the next request can only
  // rise one cycle later, which gives the mandatory idle gap.
  always_comb begin
    w_nstate = r_state;
    w_issue  = 1'b0;
    w_opa    = '0;
    w_opb    = '0;
    case (r_state)
      S_IDLE: if (in_valid) w_nstate = S_CLS;
      S_CLS: begin
        if (w_is_inf)      w_nstate = S_OUT;
        else if (w_same_x) w_nstate = S_NUM;
        else               w_nstate = S_INV;
      end
      S_NUM: begin
        w_opa = r_px;
        w_opb = r_px;
        if (!r_mm_req) w_issue = 1'b1;
        else if (w_done) w_nstate = S_INV;
      end
      S_INV: begin
        w_opa = r_acc;
        w_opb = r_phase ? r_den : r_acc;
        if (!r_mm_req) w_issue = 1'b1;
        else if (w_done && !(!r_phase && w_ebit) && (r_bit == '0))
          w_nstate = S_LAM;
      end
      S_LAM: begin
        w_opa = r_num;
        w_opb = r_acc;
        if (!r_mm_req) w_issue = 1'b1;
        else if (w_done) w_nstate = S_LSQ;
      end
      S_LSQ: begin
        w_opa = r_lam;
        w_opb = r_lam;
        if (!r_mm_req) w_issue = 1'b1;
        else if (w_done) w_nstate = S_RX;
      end
      S_RX: w_nstate = S_RYM;
      S_RYM: begin
        w_opa = r_lam;
        w_opb = mod_sub(r_px, r_rx, r_p);
        if (!r_mm_req) w_issue = 1'b1;
        else if (w_done) w_nstate = S_OUT;
      end
      S_OUT:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  // Multiplier request register: operands are frozen for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mm_req <= 1'b0;
      r_mm_a   <= '0;
      r_mm_b   <= '0;
      r_mm_p   <= '0;
    end else if (w_issue) begin
      r_mm_req <= 1'b1;
      r_mm_a   <= w_opa;
      r_mm_b   <= w_opb;
      r_mm_p   <= r_p;
    end else if (w_done) begin
      r_mm_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_px, r_py, r_qx, r_qy, r_p, r_a} <= '0;
      {r_num, r_den, r_acc, r_lam, r_t, r_rx, r_ry} <= '0;
      r_inf   <= 1'b0;
      r_bit   <= '0;
      r_phase <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_px  <= in_Px;
          r_py  <= in_Py;
          r_qx  <= in_Qx;
          r_qy  <= in_Qy;
          r_p   <= in_prime;
          r_a   <= in_a;
          r_inf <= 1'b0;
          r_rx  <= '0;
          r_ry  <= '0;
        end
        S_CLS: begin
          r_acc   <= W'(1);
          r_bit   <= IW'(W - 1);
          r_phase <= 1'b0;
          if (w_is_inf) begin
            r_inf <= 1'b1;
            r_rx  <= '0;
            r_ry  <= '0;
          end else if (w_same_x) begin
            r_den <= mod_add(r_py, r_py, r_p);
          end else begin
            r_num <= mod_sub(r_qy, r_py, r_p);
            r_den <= mod_sub(r_qx, r_px, r_p);
          end
        end
        S_NUM: if (w_done)
          r_num <= mod_add(mod_add(mod_add(mm.mm_res, mm.mm_res, r_p),
                                   mm.mm_res, r_p), r_a, r_p);
        S_INV: if (w_done) begin
          r_acc <= mm.mm_res;
          if (!r_phase && w_ebit) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (r_bit != '0) r_bit <= r_bit - IW'(1);
          end
        end
        S_LAM: if (w_done) r_lam <= mm.mm_res;
        S_LSQ: if (w_done) r_t <= mm.mm_res;
        S_RX:  r_rx <= mod_sub(mod_sub(r_t, r_px, r_p), r_qx, r_p);
        S_RYM: if (w_done) r_ry <= mod_sub(mm.mm_res, r_py, r_p);
        default: ;
      endcase
    end
  end

  assign mm.mm_req = r_mm_req;
  assign mm.mm_a   = r_mm_a;
  assign mm.mm_b   = r_mm_b;
  assign mm.mm_p   = r_mm_p;

  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign out_Rx    = out_valid ? r_rx : '0;
  assign out_Ry    = out_valid ? r_ry : '0;
  assign out_inf   = out_valid & r_inf;
endmodule
`default_nettype wire

// File: tb/tb_ec_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ec_op_sequencer
// Purpose  : Self-checking bench for ec_op_sequencer. Plays the shared
//            multiplier with random ack latency, checks the request protocol
//            every cycle, and compares each result with an integer model of
//            the curve group law (modular inverse found by search).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ec_op_sequencer;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a;
  logic         busy, out_valid, out_inf;
  logic [W-1:0] out_Rx, out_Ry;

  ec_op_sequencer_if #(.W(W)) mm_bus ();

  ec_op_sequencer #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_Px    (in_Px),
    .in_Py    (in_Py),
    .in_Qx    (in_Qx),
    .in_Qy    (in_Qy),
    .in_prime (in_prime),
    .in_a     (in_a),
    .busy     (busy),
    .out_valid(out_valid),
    .out_Rx   (out_Rx),
    .out_Ry   (out_Ry),
    .out_inf  (out_inf),
    .mm       (mm_bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int max_dly = 0;
  int wait_cnt = 0;
  int mm_pulses = 0;
  int ov_count = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic [3*W-1:0] prev_ops = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int md(input int v, input int p);
    int r;
    r = v % p;
    if (r < 0) r += p;
    return r;
  endfunction

  // Group law with plain integers; inverse found by exhaustive search.
  task automatic ref_model(input int px, py, qx, qy, p, a,
                           output int rx, ry, inf, nmul);
    int num, den, inv, lam;
    if (px == qx && (py != qy || py == 0)) begin
      rx = 0; ry = 0; inf = 1; nmul = 0;
      return;
    end
    if (px == qx) begin
      num = md(3 * px * px + a, p); den = md(2 * py, p); nmul = 10;
    end else begin
      num = md(qy - py, p); den = md(qx - px, p); nmul = 9;
    end
    nmul += $countones(p - 2);
    inv = 0;
    for (int x = 1; x < p; x++) if (md(den * x, p) == 1) inv = x;
    lam = md(num * inv, p);
    rx  = md(lam * lam - px - qx, p);
    ry  = md(lam * (px - rx) - py, p);
    inf = 0;
  endtask

  // One clock: advance to the falling edge, check the multiplier protocol,
  // and play the multiplier's side of the handshake.
  task automatic tick();
    logic [3*W-1:0] ops;
    @(negedge clk);
    ops = {mm_bus.mm_a, mm_bus.mm_b, mm_bus.mm_p};
    if (!rst_n) begin
      mm_bus.mm_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      if (prev_ack) chk("req_gap_after_ack", {31'd0, mm_bus.mm_req}, 32'd0);
      if (prev_req && !prev_ack && mm_bus.mm_req)
        chk("mm_operands_stable", {14'd0, ops}, {14'd0, prev_ops});
      if (mm_bus.mm_req && !prev_req) mm_pulses++;
      if (out_valid) ov_count++;
      if (mm_bus.mm_ack) begin
        mm_bus.mm_ack = 1'b0;
      end else if (mm_bus.mm_req) begin
        if (wait_cnt == 0) begin
          mm_bus.mm_ack = 1'b1;
          mm_bus.mm_res = (mm_bus.mm_p == '0) ? '0 :
              W'((int'(mm_bus.mm_a) * int'(mm_bus.mm_b)) % int'(mm_bus.mm_p));
          wait_cnt = $urandom_range(0, max_dly);
        end else begin
          wait_cnt--;
        end
      end
    end
    prev_req = mm_bus.mm_req;
    prev_ack = mm_bus.mm_ack;
    prev_ops = ops;
  endtask

  task automatic run_op(input string tag, input int px, py, qx, qy, p, a,
                        input bit inject);
    int erx, ery, einf, enm;
    bit seen;
    ref_model(px, py, qx, qy, p, a, erx, ery, einf, enm);
    mm_pulses = 0;
    ov_count  = 0;
    in_Px = W'(px); in_Py = W'(py); in_Qx = W'(qx); in_Qy = W'(qy);
    in_prime = W'(p); in_a = W'(a);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (inject && c == 3) begin
        in_valid = 1'b1;
        in_Px = 6'd1; in_Py = 6'd2; in_Qx = 6'd3; in_Qy = 6'd4;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      seen = out_valid;
    end
    in_valid = 1'b0;
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_Rx"},  {26'd0, out_Rx}, erx);
      chk({tag, "_Ry"},  {26'd0, out_Ry}, ery);
      chk({tag, "_inf"}, {31'd0, out_inf}, einf);
      tick();
      chk({tag, "_after"}, {15'd0, out_valid, busy, out_inf, out_Rx, out_Ry}, 32'd0);
      chk({tag, "_pulses"}, ov_count, 32'd1);
      chk({tag, "_mm_count"}, mm_pulses, enm);
    end
  endtask

  initial begin
    int primes [0:16] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};
    int p, a, px, py, qx, qy, mode;
    bit hit;
    rst_n = 1'b0;
    in_valid = 1'b0;
    {in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a} = '0;
    mm_bus.mm_ack = 1'b0;
    mm_bus.mm_res = '0;
    repeat (3) tick();
    chk("reset_outputs", {16'd0, busy, out_valid, out_inf, mm_bus.mm_req, out_Rx, out_Ry}, 32'd0);
    chk("reset_mm_bus", {14'd0, mm_bus.mm_a, mm_bus.mm_b, mm_bus.mm_p}, 32'd0);
    rst_n = 1'b1;
    tick();

    max_dly = 0;
    run_op("add_basic", 5, 1, 6, 3, 17, 2, 1'b0);
    run_op("double_basic", 5, 1, 5, 1, 17, 2, 1'b0);
    run_op("inverse_pts", 5, 1, 5, 16, 17, 2, 1'b0);
    run_op("double_y0", 7, 0, 7, 0, 17, 2, 1'b0);
    max_dly = 5;
    run_op("add_slow_ack", 5, 1, 6, 3, 17, 2, 1'b0);
    run_op("add_inject", 5, 1, 6, 3, 17, 2, 1'b1);

    // Reset in the middle of the inversion.
    mm_pulses = 0;
    in_Px = 6'd5; in_Py = 6'd1; in_Qx = 6'd6; in_Qy = 6'd3; in_prime = 6'd17; in_a = 6'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      tick();
      hit = (mm_pulses >= 2) && mm_bus.mm_req;
    end
    chk("midinv_reached", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, mm_bus.mm_req}, 32'd0);
    tick();
    chk("midinv_reset_outputs", {16'd0, busy, out_valid, out_inf, mm_bus.mm_req, out_Rx, out_Ry}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_reset", 5, 1, 6, 3, 17, 2, 1'b0);

    for (int n = 0; n < 30; n++) begin
      p  = primes[$urandom_range(0, 16)];
      a  = $urandom_range(0, p - 1);
      px = $urandom_range(0, p - 1);
      py = $urandom_range(0, p - 1);
      qx = $urandom_range(0, p - 1);
      qy = $urandom_range(0, p - 1);
      mode = $urandom_range(0, 7);
      if (mode < 2) begin
        qx = px; qy = py;
      end else if (mode == 2) begin
        qx = px;
      end
      max_dly = $urandom_range(0, 5);
      run_op($sformatf("rand%0d", n), px, py, qx, qy, p, a, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
